// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: memop codes, MemtoReg selects, MEM/WB register layout.
// Also provides the access-size decode used by the lane logic.
package mem_pkg;

  localparam logic [2:0] MEMOP_W  = 3'b000;
  localparam logic [2:0] MEMOP_BS = 3'b001;
  localparam logic [2:0] MEMOP_BU = 3'b010;
  localparam logic [2:0] MEMOP_HS = 3'b011;
  localparam logic [2:0] MEMOP_HU = 3'b100;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_DM  = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [4:0]  a3;
    logic [31:0] aluout;
    logic [31:0] dmout;
    logic [31:0] pc;
    logic        excep;
  } wb_t;

  localparam wb_t WB_BUBBLE = '0;

  // Reserved codes 101-111 fall through to a word access.
  function automatic acc_size_e acc_size(input logic [2:0] memop);
    acc_size_e sz;
    case (memop)
      MEMOP_BS, MEMOP_BU: sz = SZ_BYTE;
      MEMOP_HS, MEMOP_HU: sz = SZ_HALF;
      default:            sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_signed_load(input logic [2:0] memop);
    return (memop == MEMOP_BS) || (memop == MEMOP_HS);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// MEM-stage bus: control/data from EX/MEM into the stage, registered MEM/WB fields out to WB.
// master = upstream pipeline driver, slave = mem_stage.
interface mem_stage_if;

  logic        stall;
  logic        flush;
  logic        MemWrite_mem;
  logic [2:0]  memop_mem;
  logic [1:0]  MemtoReg_mem;
  logic        RegWrite_mem;
  logic [4:0]  A3_mem;
  logic [31:0] aluout_mem;
  logic [31:0] wdata_mem;
  logic [31:0] pc_mem;

  logic [1:0]  MemtoReg_wb;
  logic        RegWrite_wb;
  logic [4:0]  A3_wb;
  logic [31:0] aluout_wb;
  logic [31:0] dmout_wb;
  logic [31:0] pc_wb;
  logic        excep_wb;

  modport master (
    output stall, flush, MemWrite_mem, memop_mem, MemtoReg_mem, RegWrite_mem,
           A3_mem, aluout_mem, wdata_mem, pc_mem,
    input  MemtoReg_wb, RegWrite_wb, A3_wb, aluout_wb, dmout_wb, pc_wb, excep_wb
  );

  modport slave (
    input  stall, flush, MemWrite_mem, memop_mem, MemtoReg_mem, RegWrite_mem,
           A3_mem, aluout_mem, wdata_mem, pc_mem,
    output MemtoReg_wb, RegWrite_wb, A3_wb, aluout_wb, dmout_wb, pc_wb, excep_wb
  );

endinterface

// File: rtl/dm_ext.sv
// Data-memory lane logic: store byte-enables and lane-replicated write data, load extract/extend.
// Purely combinational; MEM_ALIGN_CHECK_EN enables the misaligned-access flag, otherwise tied 0.
module dm_ext
  import mem_pkg::*;
(
  input  logic [2:0]  memop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  acc_size_e   size;
  logic        sext;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign size = acc_size(memop_i);
  assign sext = is_signed_load(memop_i);

  always_comb begin
    lbyte = rword_i[7:0];
    case (addr_lo_i)
      2'd1:    lbyte = rword_i[15:8];
      2'd2:    lbyte = rword_i[23:16];
      2'd3:    lbyte = rword_i[31:24];
      default: lbyte = rword_i[7:0];
    endcase
    lhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Write data is replicated across lanes so the byte-enables alone select what lands.
  always_comb begin
    be_o    = 4'b1111;
    wword_o = wdata_i;
    ldata_o = rword_i;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{sext & lbyte[7]}}, lbyte};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        ldata_o = {{16{sext & lhalf[15]}}, lhalf};
      end
      default: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        ldata_o = rword_i;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_o = ((size == SZ_WORD) && (addr_lo_i != 2'b00)) ||
                      ((size == SZ_HALF) && addr_lo_i[0]);
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM stage + MEM/WB register: byte-enabled synchronous data memory, load extend, 1-cycle MEM->WB.
// stall holds MEM/WB and blocks the store; flush (wins over stall) bubbles WB. MEM_ALIGN_CHECK_EN adds excep_wb.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DM_WORDS  = 1024,
  parameter int DM_ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  logic [31:0]          dm_q [DM_WORDS];
  logic [DM_ADDR_W-1:0] widx;
  logic [31:0]          rword;
  logic [3:0]           be;
  logic [31:0]          wword;
  logic [31:0]          ldata;
  logic                 misalign;
  logic                 is_access;
  logic                 fault;
  logic                 store_en;
  wb_t                  wb_d;
  wb_t                  wb_q;

  // Upper address bits are dropped so accesses wrap modulo DM_WORDS.
  assign widx  = bus.aluout_mem[DM_ADDR_W+1:2];
  assign rword = dm_q[widx];

  dm_ext u_dm_ext (
    .memop_i    (bus.memop_mem),
    .addr_lo_i  (bus.aluout_mem[1:0]),
    .wdata_i    (bus.wdata_mem),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .ldata_o    (ldata),
    .misalign_o (misalign)
  );

  // Only real memory instructions can fault; ALU ops leave arbitrary values in aluout.
  assign is_access = bus.MemWrite_mem | (bus.MemtoReg_mem == MTR_DM);
  assign fault     = misalign & is_access;
  assign store_en  = bus.MemWrite_mem & ~bus.stall & ~bus.flush & ~reset & ~fault;

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) dm_q[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_comb begin
    wb_d            = WB_BUBBLE;
    wb_d.mem_to_reg = bus.MemtoReg_mem;
    wb_d.reg_write  = bus.RegWrite_mem & ~fault;
    wb_d.a3         = bus.A3_mem;
    wb_d.aluout     = bus.aluout_mem;
    wb_d.dmout      = ldata;
    wb_d.pc         = bus.pc_mem;
    wb_d.excep      = fault;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= WB_BUBBLE;
    end else if (bus.flush) begin
      wb_q <= WB_BUBBLE;
    end else if (!bus.stall) begin
      wb_q <= wb_d;
    end
  end

  assign bus.MemtoReg_wb = wb_q.mem_to_reg;
  assign bus.RegWrite_wb = wb_q.reg_write;
  assign bus.A3_wb       = wb_q.a3;
  assign bus.aluout_wb   = wb_q.aluout;
  assign bus.dmout_wb    = wb_q.dmout;
  assign bus.pc_wb       = wb_q.pc;
  assign bus.excep_wb    = wb_q.excep;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against a byte-array memory model.
// Expected MEM/WB contents come from the model; directed cases also check literal load results.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int DM_WORDS = 1024;
  localparam int DM_BYTES = DM_WORDS * 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.DM_WORDS(DM_WORDS), .DM_ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   ref_mem [DM_BYTES];
  logic [104:0] exp_wb;
  logic [104:0] obs_wb;
  assign obs_wb = {bus.MemtoReg_wb, bus.RegWrite_wb, bus.A3_wb, bus.aluout_wb,
                   bus.dmout_wb, bus.pc_wb, bus.excep_wb};

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    int unsigned a, b;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [31:0] v;
    a = addr % DM_BYTES;
    case (op)
      3'd1: begin sb = ref_mem[a]; v = 32'(sb); end
      3'd2: v = 32'(ref_mem[a]);
      3'd3: begin b = a - a % 2; sh = {ref_mem[b+1], ref_mem[b]}; v = 32'(sh); end
      3'd4: begin b = a - a % 2; v = 32'({ref_mem[b+1], ref_mem[b]}); end
      default: begin b = a - a % 4; v = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]}; end
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
    int unsigned a, b;
    a = addr % DM_BYTES;
    case (op)
      3'd1, 3'd2: ref_mem[a] = d[7:0];
      3'd3, 3'd4: begin b = a - a % 2; ref_mem[b] = d[7:0]; ref_mem[b+1] = d[15:8]; end
      default: begin
        b = a - a % 4;
        for (int k = 0; k < 4; k++) ref_mem[b+k] = d[8*k +: 8];
      end
    endcase
  endtask

  function automatic logic ref_fault(input logic [2:0] op, input logic [31:0] addr,
                                     input logic we, input logic [1:0] mtr);
    int unsigned a;
    logic acc, mis;
    a   = addr % 4;
    acc = we || (mtr == 2'b01);
    if (op == 3'd1 || op == 3'd2)      mis = 1'b0;
    else if (op == 3'd3 || op == 3'd4) mis = (a % 2) != 0;
    else                               mis = a != 0;
    return ALIGN_EN && acc && mis;
  endfunction

  // Advance one clock: update model expectation/memory from the inputs presented this cycle.
  task automatic clk_step();
    logic [31:0] ld;
    logic flt;
    ld  = ref_load(bus.memop_mem, bus.aluout_mem);
    flt = ref_fault(bus.memop_mem, bus.aluout_mem, bus.MemWrite_mem, bus.MemtoReg_mem);
    if (reset || bus.flush) exp_wb = '0;
    else if (!bus.stall)
      exp_wb = {bus.MemtoReg_mem, bus.RegWrite_mem & ~flt, bus.A3_mem, bus.aluout_mem,
                ld, bus.pc_mem, flt};
    if (bus.MemWrite_mem && !bus.stall && !bus.flush && !reset && !flt)
      ref_store(bus.memop_mem, bus.aluout_mem, bus.wdata_mem);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] op, input logic [1:0] mtr,
                       input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic st, input logic fl);
    bus.MemWrite_mem = we;
    bus.memop_mem    = op;
    bus.MemtoReg_mem = mtr;
    bus.RegWrite_mem = rw;
    bus.A3_mem       = 5'($urandom_range(1, 31));
    bus.aluout_mem   = addr;
    bus.wdata_mem    = wd;
    bus.pc_mem       = $urandom & 32'hFFFF_FFFC;
    bus.stall        = st;
    bus.flush        = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 3'd0, 2'b01, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      clk_step();
      total++;
      if (obs_wb !== 105'h0) begin
        bad++;
        $display("FAIL reset_bubble got=%h exp=0", obs_wb);
      end
    end
    reset = 1'b0;
  endtask

  task automatic preinit();
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 3'd0, 2'b00, 1'b0, 32'(w * 4), $urandom, 1'b0, 1'b0);
      clk_step();
    end
    drive(1'b0, 3'd0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    clk_step();
  endtask

  task automatic test_store_load();
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h10, 32'h8000_00F0, 1'b0, 1'b0);
    clk_step();
    drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    clk_step();
    total++;
    if (bus.dmout_wb !== 32'h8000_00F0 || bus.MemtoReg_wb !== 2'b01) begin
      bad++;
      $display("FAIL sw_lw dmout=%h mtr=%b exp dmout=800000f0 mtr=01", bus.dmout_wb, bus.MemtoReg_wb);
    end
    total++;
    if (obs_wb !== exp_wb) begin
      bad++;
      $display("FAIL sw_lw_fields got=%h exp=%h", obs_wb, exp_wb);
    end
  endtask

  task automatic test_lanes();
    logic [2:0]  ops   [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] addrs [3] = '{32'h20, 32'h21, 32'h22};
    logic [31:0] exps  [3] = '{32'hFFFF_FFF0, 32'h0000_0080, 32'h0000_1234};
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h20, 32'h1234_80F0, 1'b0, 1'b0);
    clk_step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, ops[i], 2'b01, 1'b1, addrs[i], $urandom, 1'b0, 1'b0);
      clk_step();
      total++;
      if (bus.dmout_wb !== exps[i] || obs_wb !== exp_wb) begin
        bad++;
        $display("FAIL load_lane%0d dmout=%h exp=%h", i, bus.dmout_wb, exps[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 1'b0);
    clk_step();
    drive(1'b1, 3'd1, 2'b00, 1'b0, 32'h23, 32'h5566_77AB, 1'b0, 1'b0);
    clk_step();
    drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
    clk_step();
    total++;
    if (bus.dmout_wb !== 32'hAB22_3344) begin
      bad++;
      $display("FAIL sb_merge got=%h exp=ab223344", bus.dmout_wb);
    end
    drive(1'b1, 3'd3, 2'b00, 1'b0, 32'h20, 32'h1234_BEEF, 1'b0, 1'b0);
    clk_step();
    drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
    clk_step();
    total++;
    if (bus.dmout_wb !== 32'hAB22_BEEF || obs_wb !== exp_wb) begin
      bad++;
      $display("FAIL sh_merge got=%h exp=ab22beef", bus.dmout_wb);
    end
  endtask

  task automatic test_stall();
    logic [104:0] held;
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h30, 32'h0BAD_0BAD, 1'b0, 1'b0);
    clk_step();
    held = obs_wb;
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h30, 32'hCAFE_F00D, 1'b1, 1'b0);
    clk_step();
    clk_step();
    total++;
    if (obs_wb !== held || obs_wb !== exp_wb) begin
      bad++;
      $display("FAIL stall_hold got=%h exp=%h", obs_wb, held);
    end
    drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, 1'b0);
    clk_step();
    total++;
    if (bus.dmout_wb !== 32'h0BAD_0BAD) begin
      bad++;
      $display("FAIL stall_no_store got=%h exp=0bad0bad", bus.dmout_wb);
    end
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h30, 32'hCAFE_F00D, 1'b1, 1'b0);
    clk_step();
    bus.stall = 1'b0;
    clk_step();
    drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, 1'b0);
    clk_step();
    total++;
    if (bus.dmout_wb !== 32'hCAFE_F00D || obs_wb !== exp_wb) begin
      bad++;
      $display("FAIL stall_release got=%h exp=cafef00d", bus.dmout_wb);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h34, 32'h7777_1111, 1'b0, 1'b0);
    clk_step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd0, 2'b01, 1'b1, 32'h34, 32'h9999_0000, i == 1, 1'b1);
      clk_step();
      total++;
      if (obs_wb !== 105'h0) begin
        bad++;
        $display("FAIL flush_bubble%0d got=%h exp=0", i, obs_wb);
      end
      drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h34, 32'h0, 1'b0, 1'b0);
      clk_step();
      total++;
      if (bus.dmout_wb !== 32'h7777_1111) begin
        bad++;
        $display("FAIL flush_no_store%0d got=%h exp=77771111", i, bus.dmout_wb);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd0, 2'b00, 1'b0, 32'h38, 32'h1357_9BDF, 1'b0, 1'b0);
    clk_step();
    reset = 1'b1;
    drive(1'b1, 3'd0, 2'b01, 1'b1, 32'h38, 32'hFFFF_0000, 1'b0, 1'b0);
    clk_step();
    reset = 1'b0;
    total++;
    if (obs_wb !== 105'h0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0", obs_wb);
    end
    drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h38, 32'h0, 1'b0, 1'b0);
    clk_step();
    total++;
    if (bus.dmout_wb !== 32'h1357_9BDF) begin
      bad++;
      $display("FAIL reset_keeps_mem got=%h exp=13579bdf", bus.dmout_wb);
    end
    drive(1'b0, 3'd0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b0, 1'b0);
    clk_step();
    total++;
`ifdef MEM_ALIGN_CHECK_EN
    if (bus.excep_wb !== 1'b1 || bus.RegWrite_wb !== 1'b0) begin
      bad++;
      $display("FAIL misalign_lw excep=%b rw=%b exp excep=1 rw=0", bus.excep_wb, bus.RegWrite_wb);
    end
`else
    if (bus.excep_wb !== 1'b0 || bus.RegWrite_wb !== 1'b1 || bus.dmout_wb !== 32'h8000_00F0) begin
      bad++;
      $display("FAIL unaligned_lw excep=%b rw=%b dmout=%h exp 0 1 800000f0",
               bus.excep_wb, bus.RegWrite_wb, bus.dmout_wb);
    end
`endif
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
            $urandom_range(0, 1), ($urandom & 32'hFFFF_F000) | $urandom_range(0, 63),
            $urandom, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
      clk_step();
      total++;
      if (obs_wb !== exp_wb) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL random_cyc%0d got=%h exp=%h", i, obs_wb, exp_wb);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    preinit();
    test_store_load();
    test_lanes();
    test_partial_store();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
